// File: rtl/sound_pkg.sv
// Shared types, constants and the saturation helper for the sound mixer.
package sound_pkg;

    typedef logic signed [15:0] sample_t;

    // Offset-binary midpoint of a generator channel.
    localparam logic [15:0] SILENCE    = 16'h8000;
    localparam int          SAMPLE_MAX = 32767;
    localparam int          SAMPLE_MIN = -32768;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ACC  = 3'd1,
        SAT  = 3'd2,
        FILT = 3'd3,
        OUT  = 3'd4
    } mix_state_t;

    // Clamp a wide signed value into the signed 16-bit sample range.
    function automatic sample_t sat16(input logic signed [63:0] v);
        if (v > 64'(SAMPLE_MAX)) begin
            return sample_t'(SAMPLE_MAX);
        end else if (v < 64'(SAMPLE_MIN)) begin
            return sample_t'(SAMPLE_MIN);
        end else begin
            return sample_t'(v[15:0]);
        end
    endfunction

endpackage

// File: rtl/one_pole_lpf.sv
// One-pole low-pass filter with 16.8 signed state; k = 0 passes x straight through.
module one_pole_lpf
    import sound_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  sample_t             x,
    input  logic [2:0]          k,
    output logic signed [23:0]  y
);

    logic signed [23:0] y_q;
    logic signed [23:0] y_d;
    logic signed [24:0] target;
    logic signed [24:0] diff;
    logic signed [24:0] step;

    // Next filter state: move y toward x<<8 by 1/2^k of the remaining distance.
    always_comb begin
        target = $signed({x[15], x, 8'h00});
        diff   = target - $signed({y_q[23], y_q});
        step   = diff >>> k;
        y_d    = y_q;
        if (en) begin
            if (k == 3'd0) begin
                y_d = target[23:0];
            end else begin
                y_d = y_q + step[23:0];
            end
        end
    end

    // Filter state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: rtl/sound_mixer.sv
// Snapshot, gain, sum, saturate and low-pass the generator channels once per 48 kHz strobe.
// Strobe handshake: clk_48KHz_en is a one-cycle request accepted only in IDLE; busy is high
// while a sample is in flight, a strobe seen while busy is dropped and sets sticky overrun,
// and out_valid pulses for one cycle when out takes the new sample.
module sound_mixer
    import sound_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int GAIN_W = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             clk_48KHz_en,
    input  logic [NUM_CH-1:0][15:0]          ch_in,
    input  logic [NUM_CH-1:0][GAIN_W-1:0]    ch_gain,
    input  logic [2:0]                       lpf_k,
    input  logic                             mute,
    output logic [15:0]                      out,
    output logic                             out_valid,
    output logic                             busy,
    output logic                             overrun,
    output mix_state_t                       dbg_state
);

    localparam int ACC_W  = 16 + GAIN_W + $clog2(NUM_CH) + 1;
    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PROD_W = 17 + GAIN_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    mix_state_t                        state_q, state_d;
    logic [NUM_CH-1:0][15:0]           snap_ch_q, snap_ch_d;
    logic [NUM_CH-1:0][GAIN_W-1:0]     snap_gain_q, snap_gain_d;
    logic signed [ACC_W-1:0]           acc_q, acc_d;
    logic [IDX_W-1:0]                  idx_q, idx_d;
    sample_t                           x_q, x_d;
    logic [15:0]                       out_q, out_d;
    logic                              out_valid_q, out_valid_d;
    logic                              busy_q, busy_d;
    logic                              overrun_q, overrun_d;

    logic signed [15:0]                cur_s;
    logic signed [GAIN_W:0]            cur_g;
    logic signed [PROD_W-1:0]          prod;
    logic signed [ACC_W-1:0]           acc_sh;
    logic signed [23:0]                y_state;

    // Single time-shared multiplier: current snapshot channel times its gain.
    always_comb begin
        cur_s  = $signed(snap_ch_q[idx_q] ^ SILENCE);
        cur_g  = $signed({1'b0, snap_gain_q[idx_q]});
        prod   = cur_s * cur_g;
        acc_sh = acc_q >>> 8;
    end

    one_pole_lpf u_lpf (
        .clk (clk),
        .rst (reset),
        .en  (state_q == FILT),
        .x   (x_q),
        .k   (lpf_k),
        .y   (y_state)
    );

    // Sequencer: next state and datapath register updates.
    always_comb begin
        state_d     = state_q;
        snap_ch_d   = snap_ch_q;
        snap_gain_d = snap_gain_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        x_d         = x_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        overrun_d   = overrun_q;

        if (clk_48KHz_en && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (clk_48KHz_en) begin
                    snap_ch_d   = ch_in;
                    snap_gain_d = ch_gain;
                    acc_d       = '0;
                    idx_d       = '0;
                    state_d     = ACC;
                end
            end
            ACC: begin
                acc_d = acc_q + ACC_W'(prod);
                if (idx_q == LAST_IDX) begin
                    state_d = SAT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            SAT: begin
                x_d     = sat16(64'(acc_sh));
                state_d = FILT;
            end
            FILT: begin
                state_d = OUT;
            end
            OUT: begin
                out_d       = mute ? 16'h0000 : y_state[23:8];
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and datapath registers; reset aborts any sample in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            snap_ch_q   <= '0;
            snap_gain_q <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            x_q         <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            snap_ch_q   <= snap_ch_d;
            snap_gain_q <= snap_gain_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            x_q         <= x_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;
    assign dbg_state = state_q;

endmodule

// File: doc/sound_mixer.md
# sound_mixer

Downstream audio stage that consumes the 48 kHz offset-binary channel outputs of the sound generators (bang, explosion, engine, shell, …). On every 48 kHz strobe it snapshots all channels, applies per-channel gain with one time-multiplexed multiplier, sums, saturates, and runs a one-pole low-pass. It produces the single signed 16-bit sample handed to the audio output path.

## Interface
- NUM_CH, 4, number of input channels (1..16)
- GAIN_W, 8, per-channel gain width; gain is unsigned, value/256
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- clk_48KHz_en  in  1  one-cycle sample strobe
- ch_in  in  NUM_CH×16  per-channel samples, offset-binary (0x8000 = silence)
- ch_gain  in  NUM_CH×GAIN_W  per-channel gain
- lpf_k  in  3  filter shift; 0 = bypass
- mute  in  1  forces output to 0
- out  out  16  signed mixed sample
- out_valid  out  1  one-cycle pulse when out updates
- busy  out  1  high while a sample is in flight
- overrun  out  1  sticky; strobe arrived while busy

## Operation
- FSM states: IDLE, ACC, SAT, FILT, OUT.
- IDLE: on clk_48KHz_en, latch all ch_in and ch_gain into snapshot registers, clear accumulator and channel index, go to ACC, set busy.
- ACC: one channel per cycle. s = ch_in[i] − 0x8000 as signed 16. acc += s × ch_gain[i], with gain zero-extended to signed. Accumulator width is 16+GAIN_W+ceil(log2 NUM_CH)+1 with no wrap. After channel NUM_CH−1, go to SAT.
- SAT: x = acc >>> 8 (arithmetic), clamped to [−32768, 32767].
- FILT, with y held as 24-bit signed state (16.8):
  - If lpf_k = 0: y = x<<8.
  - Otherwise: y += ((x<<8) − y) >>> lpf_k.
- OUT:
  - out = mute ? 0 : y[23:8].
  - Pulse out_valid, clear busy, return to IDLE.
  - The filter state keeps updating while muted.
- Strobe while busy is ignored (no re-latch), and overrun is set to 1. overrun clears only on reset.
- ch_in and ch_gain changes after the snapshot do not affect the sample in flight. lpf_k and mute are sampled in FILT and OUT respectively.

## Timing
- Strobe at cycle 0 → ACC occupies cycles 1..NUM_CH → SAT at NUM_CH+1 → FILT at NUM_CH+2 → OUT at NUM_CH+3.
- out and out_valid are registered and visible in the cycle after OUT, at NUM_CH+4; latency is NUM_CH+4 clocks.
- busy is high from cycle 1 through NUM_CH+3 inclusive. A strobe at cycle NUM_CH+4 is accepted.
- out holds its value between updates.
- Reset values: out=0, out_valid=0, busy=0, overrun=0, y=0, accumulator=0, FSM=IDLE.
- Reset asserted mid-sample aborts immediately. No out_valid is produced for that sample.

## Structure
- Package sound_pkg holds:
  - sample_t (logic signed [15:0])
  - offset constant SILENCE = 16'h8000
  - SAMPLE_MAX/SAMPLE_MIN
  - mixer state enum mix_state_t
- Sub-module one_pole_lpf (x, k, y-state update, registered y) holds the FILT arithmetic. Instantiate it once.
- Saturation is an inline function in sound_pkg.

## Test plan
- Reset: hold reset with random inputs → out=0, out_valid=0, busy=0, overrun=0. Release, send no strobe → outputs remain 0.
- Single channel: ch0=0xC000, gain0=128, others 0x8000, lpf_k=0, strobe → out=0x2000 (8192) with out_valid exactly NUM_CH+4 clocks after strobe. Any ch_in change at cycle 2 does not alter the result.
- Saturation:
  - All four channels 0xFFFF with gain 255 → out=32767.
  - All 0x0000 with gain 255 → out=−32768 (0x8000).
  - ch0=0xFFFF, ch1=0x0000, both gain 255 → out=−1.
- Filter step: lpf_k=1, constant x=8192 from y=0 → successive outputs 4096, 6144, 7168, 7680. Switch lpf_k=0 → next output 8192.
- Overrun/mute:
  - Second strobe 2 cycles after first → ignored, single out_valid, overrun=1 and sticky.
  - mute=1 → out=0 while the filter still converges; unmute next sample → out shows converged value.
- Reset mid-ACC: assert reset at cycle 2 → busy=0, out=0 immediately. Next strobe after release produces a correct result from y=0.
